// File: rtl/legv8_pkg.sv
// Shared LEGv8 encoding definitions: operation selects, opcodes, formats and
// field geometry. The controller's regression bench imports this package to
// cross-check decode against the same constants.
package legv8_pkg;

    // Operation select as presented on opSel; codes 11-15 are illegal
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_ORR  = 4'd3,
        OP_ADDI = 4'd4,
        OP_SUBI = 4'd5,
        OP_LDUR = 4'd6,
        OP_STUR = 4'd7,
        OP_CBZ  = 4'd8,
        OP_CBNZ = 4'd9,
        OP_B    = 4'd10
    } op_sel_e;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_D,
        FMT_CB,
        FMT_B,
        FMT_ILLEGAL
    } fmt_e;

    // Opcodes, sized to their format's opcode field
    localparam logic [10:0] OPC_ADD  = 11'h458;
    localparam logic [10:0] OPC_SUB  = 11'h658;
    localparam logic [10:0] OPC_AND  = 11'h450;
    localparam logic [10:0] OPC_ORR  = 11'h550;
    localparam logic [9:0]  OPC_ADDI = 10'h244;
    localparam logic [9:0]  OPC_SUBI = 10'h344;
    localparam logic [10:0] OPC_LDUR = 11'h7C2;
    localparam logic [10:0] OPC_STUR = 11'h7C0;
    localparam logic [7:0]  OPC_CBZ  = 8'hB4;
    localparam logic [7:0]  OPC_CBNZ = 8'hB5;
    localparam logic [5:0]  OPC_B    = 6'h05;

    // Field positions and widths
    localparam int RD_LSB     = 0;
    localparam int RN_LSB     = 5;
    localparam int RM_LSB     = 16;
    localparam int REG_W      = 5;
    localparam int R_OP_LSB   = 21;
    localparam int I_OP_LSB   = 22;
    localparam int I_IMM_LSB  = 10;
    localparam int I_IMM_W    = 12;
    localparam int D_OP_LSB   = 21;
    localparam int D_IMM_LSB  = 12;
    localparam int D_IMM_W    = 9;
    localparam int CB_OP_LSB  = 24;
    localparam int CB_IMM_LSB = 5;
    localparam int CB_IMM_W   = 19;
    localparam int B_OP_LSB   = 26;
    localparam int B_IMM_W    = 26;

    function automatic fmt_e fmt_of(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_ORR: fmt_of = FMT_R;
            OP_ADDI, OP_SUBI:               fmt_of = FMT_I;
            OP_LDUR, OP_STUR:               fmt_of = FMT_D;
            OP_CBZ, OP_CBNZ:                fmt_of = FMT_CB;
            OP_B:                           fmt_of = FMT_B;
            default:                        fmt_of = FMT_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/instruction_field_packer.sv
// Combinational packer: operation select plus register/immediate fields into
// a 32-bit LEGv8 word and a legality flag.
// Build option ENCODER_RANGE_CHECK_EN: when defined, an immediate that does
// not fit its target field marks the instruction illegal instead of being
// truncated to the field's low bits.
module instruction_field_packer
    import legv8_pkg::*;
(
    input  logic [3:0]  i_op_sel,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rn,
    input  logic [4:0]  i_rm,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_legal
);

    logic w_fit_i;
    logic w_fit_d;
    logic w_fit_cb;
    logic w_fit_b;

`ifdef ENCODER_RANGE_CHECK_EN
    // I-format immediates are unsigned; the others must sign-extend cleanly
    assign w_fit_i  = (i_imm[31:I_IMM_W] == '0);
    assign w_fit_d  = (&i_imm[31:D_IMM_W-1])  || !(|i_imm[31:D_IMM_W-1]);
    assign w_fit_cb = (&i_imm[31:CB_IMM_W-1]) || !(|i_imm[31:CB_IMM_W-1]);
    assign w_fit_b  = (&i_imm[31:B_IMM_W-1])  || !(|i_imm[31:B_IMM_W-1]);
`else
    logic w_unused_imm;
    assign w_fit_i      = 1'b1;
    assign w_fit_d      = 1'b1;
    assign w_fit_cb     = 1'b1;
    assign w_fit_b      = 1'b1;
    assign w_unused_imm = ^i_imm[31:B_IMM_W];
`endif

    // Select format layout by operation; unused fields of a format are dropped
    always_comb begin
        o_word  = '0;
        o_legal = 1'b0;
        case (i_op_sel)
            OP_ADD:  begin o_word = {OPC_ADD, i_rm, 6'b0, i_rn, i_rd}; o_legal = 1'b1; end
            OP_SUB:  begin o_word = {OPC_SUB, i_rm, 6'b0, i_rn, i_rd}; o_legal = 1'b1; end
            OP_AND:  begin o_word = {OPC_AND, i_rm, 6'b0, i_rn, i_rd}; o_legal = 1'b1; end
            OP_ORR:  begin o_word = {OPC_ORR, i_rm, 6'b0, i_rn, i_rd}; o_legal = 1'b1; end
            OP_ADDI: begin o_word = {OPC_ADDI, i_imm[I_IMM_W-1:0], i_rn, i_rd}; o_legal = w_fit_i; end
            OP_SUBI: begin o_word = {OPC_SUBI, i_imm[I_IMM_W-1:0], i_rn, i_rd}; o_legal = w_fit_i; end
            OP_LDUR: begin o_word = {OPC_LDUR, i_imm[D_IMM_W-1:0], 2'b00, i_rn, i_rd}; o_legal = w_fit_d; end
            OP_STUR: begin o_word = {OPC_STUR, i_imm[D_IMM_W-1:0], 2'b00, i_rn, i_rd}; o_legal = w_fit_d; end
            OP_CBZ:  begin o_word = {OPC_CBZ, i_imm[CB_IMM_W-1:0], i_rd}; o_legal = w_fit_cb; end
            OP_CBNZ: begin o_word = {OPC_CBNZ, i_imm[CB_IMM_W-1:0], i_rd}; o_legal = w_fit_cb; end
            OP_B:    begin o_word = {OPC_B, i_imm[B_IMM_W-1:0]}; o_legal = w_fit_b; end
            default: begin o_word = '0; o_legal = 1'b0; end
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// LEGv8 instruction encoder and instruction-memory fill path. Accepts fields
// on a valid/ready handshake, encodes them in one registered stage and writes
// the words to consecutive addresses from BASE_ADDR, stopping when DEPTH words
// have been written until clear or reset.
// Build option ENCODER_RANGE_CHECK_EN (see instruction_field_packer): rejects
// immediates that do not fit their field.
module instruction_encoder
    import legv8_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              clear,
    input  logic              inValid,
    output logic              inReady,
    input  logic [3:0]        opSel,
    input  logic [4:0]        rd,
    input  logic [4:0]        rn,
    input  logic [4:0]        rm,
    input  logic [31:0]       imm,
    output logic              wrEn,
    output logic [ADDR_W-1:0] wrAddr,
    output logic [31:0]       wrData,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              error
);

    localparam logic [ADDR_W-1:0] BASE_C  = BASE_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W:0]   DEPTH_C = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]       r_wr_data;
    logic [ADDR_W:0]   r_count;
    logic              r_error;

    logic [31:0]       w_word;
    logic              w_legal;
    logic              w_full;
    logic              w_accept;
    logic [ADDR_W-1:0] w_ptr;

    instruction_field_packer u_packer (
        .i_op_sel (opSel),
        .i_rd     (rd),
        .i_rn     (rn),
        .i_rm     (rm),
        .i_imm    (imm),
        .o_word   (w_word),
        .o_legal  (w_legal)
    );

    // Pointer is derived from the count so it wraps naturally at 2**ADDR_W
    assign w_ptr    = BASE_C + r_count[ADDR_W-1:0];
    assign w_full   = (r_count == DEPTH_C);
    assign inReady  = !w_full && !clear;
    assign w_accept = inValid && inReady;

    // Encode stage: register the write, advance the count, flag rejects
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= BASE_C;
            r_wr_data <= '0;
            r_count   <= '0;
            r_error   <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_error <= 1'b0;
            if (clear) begin
                r_count <= '0;
            end else if (w_accept) begin
                if (w_legal) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= w_ptr;
                    r_wr_data <= w_word;
                    r_count   <= r_count + ONE_C;
                end else begin
                    r_error <= 1'b1;
                end
            end
        end
    end

    assign wrEn   = r_wr_en;
    assign wrAddr = r_wr_addr;
    assign wrData = r_wr_data;
    assign count  = r_count;
    assign full   = w_full;
    assign error  = r_error;

endmodule
